// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM encoding and enable bundles.
// Pure declarations; no latency or backpressure of its own.
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_e;

    typedef struct packed {
        logic pc;
        logic ifid;
        logic idex;
        logic exmem;
        logic memwb;
    } load_t;

    typedef struct packed {
        logic ifid;
        logic idex;
        logic memwb;
    } flush_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Datapath <-> hazard sequencer bundle: hazard sources in, register enables out.
// Combinational wires only; master is the datapath, slave is the sequencer.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [pipe_ctrl_pkg::REG_ADDR_W-1:0] id_rs1;
    logic [pipe_ctrl_pkg::REG_ADDR_W-1:0] id_rs2;
    logic                                 id_use_rs1;
    logic                                 id_use_rs2;
    logic                                 ex_mem_read;
    logic [pipe_ctrl_pkg::REG_ADDR_W-1:0] ex_rd;
    logic                                 ex_branch_taken;
    logic                                 mem_req;
    logic                                 mem_ready;
    logic                                 wb_halt;

    logic                                 pc_load;
    logic                                 ifid_load;
    logic                                 idex_load;
    logic                                 exmem_load;
    logic                                 memwb_load;
    logic                                 ifid_flush;
    logic                                 idex_flush;
    logic                                 memwb_flush;
    logic                                 halted;
    logic                                 mem_err;
    logic [CNT_W-1:0]                     stall_count;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
               ex_branch_taken, mem_req, mem_ready, wb_halt,
        input  pc_load, ifid_load, idex_load, exmem_load, memwb_load,
               ifid_flush, idex_flush, memwb_flush, halted, mem_err, stall_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
               ex_branch_taken, mem_req, mem_ready, wb_halt,
        output pc_load, ifid_load, idex_load, exmem_load, memwb_load,
               ifid_flush, idex_flush, memwb_flush, halted, mem_err, stall_count
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use detector: EX load whose rd (non-x0) feeds a source the ID instruction reads.
// Purely combinational, zero latency; no backpressure.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_use_rs1 & (ex_rd == id_rs1);
    assign rs2_hit  = id_use_rs2 & (ex_rd == id_rs2);
    assign load_use = ex_mem_read & (ex_rd != X0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: PC/IF-ID/ID-EX/EX-MEM/MEM-WB load+flush enables, halt and mem timeout.
// Enables are combinational from state+inputs; a pending mem_ready freezes PC..EX/MEM.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
)(
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int              WAIT_W    = 16;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                mem_err_q, mem_err_d;
    logic [CNT_W-1:0]    stall_count_q, stall_count_d;

    logic   load_use;
    logic   mem_stall;
    logic   halted;
    load_t  ld;
    flush_t fl;

    assign mem_stall = bus.mem_req & ~bus.mem_ready;

    hazard_detect u_hazard_detect (
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .id_use_rs1  (bus.id_use_rs1),
        .id_use_rs2  (bus.id_use_rs2),
        .ex_mem_read (bus.ex_mem_read),
        .ex_rd       (bus.ex_rd),
        .load_use    (load_use)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_err_q     <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_err_q     <= mem_err_d;
            stall_count_q <= stall_count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            RUN: begin
                if (bus.wb_halt) begin
                    state_d = HALT;
                end else if (mem_stall) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                // Halt beats the wait; a late ready beats the timeout.
                if (bus.wb_halt) begin
                    state_d = HALT;
                end else if (bus.mem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d   = HALT;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = HALT;
        endcase

        stall_count_d = stall_count_q;
        if (!ld.pc && state_q != HALT && stall_count_q != {CNT_W{1'b1}})
            stall_count_d = stall_count_q + 1'b1;
    end

    always_comb begin
        ld     = '0;
        fl     = '0;
        halted = 1'b0;
        if (!reset) begin
            case (state_q)
                RUN: begin
                    if (bus.wb_halt) begin
                        ld.memwb = 1'b1;
                    end else if (mem_stall) begin
                        ld.memwb = 1'b1;
                        fl.memwb = 1'b1;
                    end else if (bus.ex_branch_taken) begin
                        ld      = '1;
                        fl.ifid = 1'b1;
                        fl.idex = 1'b1;
                    end else if (load_use) begin
                        ld.idex  = 1'b1;
                        ld.exmem = 1'b1;
                        ld.memwb = 1'b1;
                        fl.idex  = 1'b1;
                    end else begin
                        ld = '1;
                    end
                end
                MEM_WAIT: begin
                    if (bus.wb_halt) begin
                        ld.memwb = 1'b1;
                    end else if (bus.mem_ready) begin
                        ld = '1;
                    end else begin
                        ld.memwb = 1'b1;
                        fl.memwb = 1'b1;
                    end
                end
                default: halted = 1'b1;
            endcase
        end
    end

    assign bus.pc_load     = ld.pc;
    assign bus.ifid_load   = ld.ifid;
    assign bus.idex_load   = ld.idex;
    assign bus.exmem_load  = ld.exmem;
    assign bus.memwb_load  = ld.memwb;
    assign bus.ifid_flush  = fl.ifid;
    assign bus.idex_flush  = fl.idex;
    assign bus.memwb_flush = fl.memwb;
    assign bus.halted      = halted;
    assign bus.mem_err     = mem_err_q;
    assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a reference model queues expected enables per cycle.
module tb_pipe_hazard_ctrl;

    localparam int TO = 4;
    localparam int CW = 16;

    // ctl bit order: {pc, ifid, idex, exmem, memwb, ifid_f, idex_f, memwb_f}
    localparam logic [7:0] C_NONE = 8'b00000_000;
    localparam logic [7:0] C_ALL  = 8'b11111_000;
    localparam logic [7:0] C_BR   = 8'b11111_110;
    localparam logic [7:0] C_LU   = 8'b00111_010;
    localparam logic [7:0] C_FRZ  = 8'b00001_001;
    localparam logic [7:0] C_HLT  = 8'b00001_000;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mrd;
        logic [4:0] rd;
        logic       br;
        logic       mq;
        logic       my;
        logic       wh;
    } stim_t;

    typedef struct packed {
        logic          known;
        logic [7:0]    ctl;
        logic          halted;
        logic          mem_err;
        logic [CW-1:0] stall;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

    pipe_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    exp_t exp_q[$];

    // Reference model state (0=run, 1=waiting on memory, 2=halted)
    int            m_state = 0;
    int            m_wcnt  = 0;
    logic          m_err   = 1'b0;
    logic [CW-1:0] m_stall = '0;
    logic          m_known = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        exp_t got;
        logic lu;
        logic [7:0] c;
        reset               = s.rst;
        bus.id_rs1          = s.rs1;
        bus.id_rs2          = s.rs2;
        bus.id_use_rs1      = s.u1;
        bus.id_use_rs2      = s.u2;
        bus.ex_mem_read     = s.mrd;
        bus.ex_rd           = s.rd;
        bus.ex_branch_taken = s.br;
        bus.mem_req         = s.mq;
        bus.mem_ready       = s.my;
        bus.wb_halt         = s.wh;

        lu = s.mrd && (s.rd != 5'd0) &&
             ((s.u1 && s.rd == s.rs1) || (s.u2 && s.rd == s.rs2));
        if (s.rst)                      c = C_NONE;
        else if (m_state == 2)          c = C_NONE;
        else if (s.wh)                  c = C_HLT;
        else if (m_state == 1)          c = s.my ? C_ALL : C_FRZ;
        else if (s.mq && !s.my)         c = C_FRZ;
        else if (s.br)                  c = C_BR;
        else if (lu)                    c = C_LU;
        else                            c = C_ALL;

        e.known   = m_known;
        e.ctl     = c;
        e.halted  = !s.rst && (m_state == 2);
        e.mem_err = m_err;
        e.stall   = m_stall;
        exp_q.push_back(e);

        @(negedge clk);
        got = exp_q.pop_front();
        check_eq("ctl", {24'h0, bus.pc_load, bus.ifid_load, bus.idex_load, bus.exmem_load,
                         bus.memwb_load, bus.ifid_flush, bus.idex_flush, bus.memwb_flush},
                 {24'h0, got.ctl});
        check_eq("halted", {31'h0, bus.halted}, {31'h0, got.halted});
        if (got.known) begin
            check_eq("mem_err", {31'h0, bus.mem_err}, {31'h0, got.mem_err});
            check_eq("stall_count", 32'(bus.stall_count), 32'(got.stall));
        end

        @(posedge clk);
        if (s.rst) begin
            m_state = 0; m_wcnt = 0; m_err = 1'b0; m_stall = '0; m_known = 1'b1;
        end else begin
            if (!c[7] && m_state != 2 && m_stall != {CW{1'b1}}) m_stall = m_stall + 1'b1;
            case (m_state)
                0: if (s.wh) m_state = 2;
                   else if (s.mq && !s.my) begin m_state = 1; m_wcnt = 0; end
                1: if (s.wh) m_state = 2;
                   else if (s.my) begin m_state = 0; m_wcnt = 0; end
                   else if (m_wcnt == TO - 1) begin m_state = 2; m_err = 1'b1; end
                   else m_wcnt++;
                default: ;
            endcase
        end
        cyc++;
        #1;
    endtask

    initial begin
        stim_t s;
        logic [CW-1:0] sc0;
        @(posedge clk);
        #1;

        // Reset two cycles, then free-running
        s = '0; s.rst = 1'b1;
        step(s); step(s);
        s = '0;
        repeat (2) step(s);

        // Load-use on rs1, x0 target, rs2 hit, rs2 match with use bit off
        sc0 = bus.stall_count;
        s = '0; s.mrd = 1'b1; s.rd = 5'd5; s.rs1 = 5'd5; s.u1 = 1'b1;
        step(s);
        check_eq("lu_stall_delta", 32'(CW'(bus.stall_count - sc0)), 32'd1);
        s.rd = 5'd0; s.rs1 = 5'd0;
        step(s);
        s = '0; s.mrd = 1'b1; s.rd = 5'd7; s.rs2 = 5'd7; s.u2 = 1'b1; s.rs1 = 5'd3; s.u1 = 1'b1;
        step(s);
        s.u2 = 1'b0;
        step(s);

        // Branch beats load-use
        sc0 = bus.stall_count;
        s = '0; s.mrd = 1'b1; s.rd = 5'd5; s.rs1 = 5'd5; s.u1 = 1'b1; s.br = 1'b1;
        step(s);
        check_eq("br_stall_delta", 32'(CW'(bus.stall_count - sc0)), 32'd0);

        // Zero-wait memory access
        s = '0; s.mq = 1'b1; s.my = 1'b1;
        step(s);

        // Three frozen cycles then ready
        sc0 = bus.stall_count;
        s = '0; s.mq = 1'b1;
        repeat (3) step(s);
        s.my = 1'b1;
        step(s);
        check_eq("wait3_stall_delta", 32'(CW'(bus.stall_count - sc0)), 32'd3);
        s = '0;
        step(s);

        // Ready arrives on the timeout cycle: ready wins
        s = '0; s.mq = 1'b1;
        repeat (4) step(s);
        s.my = 1'b1;
        step(s);
        s = '0;
        step(s);
        check_eq("late_ready_no_err", {31'h0, bus.mem_err}, 32'd0);

        // Timeout -> halt with mem_err, then reset clears it
        sc0 = bus.stall_count;
        s = '0; s.mq = 1'b1;
        repeat (7) step(s);
        check_eq("timeout_halted", {31'h0, bus.halted}, 32'd1);
        check_eq("timeout_err", {31'h0, bus.mem_err}, 32'd1);
        check_eq("timeout_stall_delta", 32'(CW'(bus.stall_count - sc0)), 32'd5);
        s = '0; s.rst = 1'b1;
        step(s);
        check_eq("reset_clears_err", {31'h0, bus.mem_err}, 32'd0);
        s = '0;
        step(s);

        // wb_halt while waiting on memory
        sc0 = bus.stall_count;
        s = '0; s.mq = 1'b1;
        repeat (2) step(s);
        s.wh = 1'b1;
        step(s);
        s = '0;
        repeat (3) step(s);
        check_eq("halt_in_wait_halted", {31'h0, bus.halted}, 32'd1);
        check_eq("halt_in_wait_err", {31'h0, bus.mem_err}, 32'd0);
        check_eq("halt_stall_frozen", 32'(CW'(bus.stall_count - sc0)), 32'd3);

        // wb_halt from RUN
        s = '0; s.rst = 1'b1;
        step(s);
        s = '0; s.wh = 1'b1;
        step(s);
        s = '0;
        repeat (2) step(s);
        s.rst = 1'b1;
        step(s);
        s = '0;
        step(s);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
